// File: rtl/tw_rom_reader_pkg.sv
// ---------------------------------------------------------------------------
// tw_rom_reader_pkg
// Shared widths and FSM state type for the twiddle-factor ROM reader.
//   D_WIDTH      : twiddle word width
//   ROMA_WIDTH   : per-ROM address width
//   BS_WIDTH     : bank-select width (16 banks per ROM)
//   DIGIT_WIDTH  : one index digit, address bits above bank-select bits
//   TW_IDX_WIDTH : full three-digit twiddle index
// ---------------------------------------------------------------------------
package tw_rom_reader_pkg;

    localparam int D_WIDTH      = 16;
    localparam int ROMA_WIDTH   = 6;
    localparam int NBANK_FIXED  = 16;
    localparam int BS_WIDTH     = 4;
    localparam int DIGIT_WIDTH  = ROMA_WIDTH + BS_WIDTH;
    localparam int TW_IDX_WIDTH = 3 * DIGIT_WIDTH;

    // Request sequencing: accept, strobe the ROMs, capture, then hold the result.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CAPT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/tw_rom_reader_bank_sel.sv
// ---------------------------------------------------------------------------
// bank_sel16
// Purely combinational 16:1 word selector, one per ROM.
//   i_data : the 16 bank read words of one ROM
//   i_sel  : bank select
//   o_data : the selected word, passed through unmodified
// ---------------------------------------------------------------------------
module bank_sel16 #(
    parameter int D_W = 16
) (
    input  logic [D_W-1:0] i_data [16],
    input  logic [3:0]     i_sel,
    output logic [D_W-1:0] o_data
);

    // A 4-bit select can only address existing banks, so no range guard is needed.
    assign o_data = i_data[i_sel];

endmodule

// File: rtl/tw_rom_reader.sv
// ---------------------------------------------------------------------------
// tw_rom_reader
// Requesting side of the twiddle-factor ROM interface. Takes one three-digit
// index, strobes the three ROMs for a single cycle, picks one bank word per
// ROM and holds the three words behind a valid/ready handshake.
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/req_ready     : request handshake; req_idx = d2|d1|d0
//   ROM_CEN                 : ROM chip enable, active-low, registered
//   MA0..MA2                : ROM addresses (upper bits of each digit)
//   ROMk_bj                 : bank j read data of ROM k
//   out_valid/out_ready     : result handshake
//   TF0..TF2                : selected twiddle words
// ---------------------------------------------------------------------------
module tw_rom_reader
    import tw_rom_reader_pkg::*;
#(
    parameter int D_W   = D_WIDTH,
    parameter int A_W   = ROMA_WIDTH,
    parameter int NBANK = NBANK_FIXED
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3*(A_W+4)-1:0]   req_idx,
    output logic                   ROM_CEN,
    output logic [A_W-1:0]         MA0,
    output logic [A_W-1:0]         MA1,
    output logic [A_W-1:0]         MA2,
    input  logic [D_W-1:0]         ROM0_b0,  ROM0_b1,  ROM0_b2,  ROM0_b3,
    input  logic [D_W-1:0]         ROM0_b4,  ROM0_b5,  ROM0_b6,  ROM0_b7,
    input  logic [D_W-1:0]         ROM0_b8,  ROM0_b9,  ROM0_b10, ROM0_b11,
    input  logic [D_W-1:0]         ROM0_b12, ROM0_b13, ROM0_b14, ROM0_b15,
    input  logic [D_W-1:0]         ROM1_b0,  ROM1_b1,  ROM1_b2,  ROM1_b3,
    input  logic [D_W-1:0]         ROM1_b4,  ROM1_b5,  ROM1_b6,  ROM1_b7,
    input  logic [D_W-1:0]         ROM1_b8,  ROM1_b9,  ROM1_b10, ROM1_b11,
    input  logic [D_W-1:0]         ROM1_b12, ROM1_b13, ROM1_b14, ROM1_b15,
    input  logic [D_W-1:0]         ROM2_b0,  ROM2_b1,  ROM2_b2,  ROM2_b3,
    input  logic [D_W-1:0]         ROM2_b4,  ROM2_b5,  ROM2_b6,  ROM2_b7,
    input  logic [D_W-1:0]         ROM2_b8,  ROM2_b9,  ROM2_b10, ROM2_b11,
    input  logic [D_W-1:0]         ROM2_b12, ROM2_b13, ROM2_b14, ROM2_b15,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [D_W-1:0]         TF0,
    output logic [D_W-1:0]         TF1,
    output logic [D_W-1:0]         TF2
);

    localparam int DIG_W = A_W + 4;

    state_t          r_state;
    state_t          w_nextState;
    logic            w_accept;
    logic            r_romCen;
    logic            r_outValid;
    logic [A_W-1:0]  r_ma    [3];
    logic [3:0]      r_bs    [3];
    logic [D_W-1:0]  r_tf    [3];
    logic [D_W-1:0]  w_sel   [3];
    logic [DIG_W-1:0] w_digit [3];
    logic [D_W-1:0]  w_rom0  [NBANK];
    logic [D_W-1:0]  w_rom1  [NBANK];
    logic [D_W-1:0]  w_rom2  [NBANK];

    assign w_rom0 = '{ROM0_b0,  ROM0_b1,  ROM0_b2,  ROM0_b3,
                      ROM0_b4,  ROM0_b5,  ROM0_b6,  ROM0_b7,
                      ROM0_b8,  ROM0_b9,  ROM0_b10, ROM0_b11,
                      ROM0_b12, ROM0_b13, ROM0_b14, ROM0_b15};
    assign w_rom1 = '{ROM1_b0,  ROM1_b1,  ROM1_b2,  ROM1_b3,
                      ROM1_b4,  ROM1_b5,  ROM1_b6,  ROM1_b7,
                      ROM1_b8,  ROM1_b9,  ROM1_b10, ROM1_b11,
                      ROM1_b12, ROM1_b13, ROM1_b14, ROM1_b15};
    assign w_rom2 = '{ROM2_b0,  ROM2_b1,  ROM2_b2,  ROM2_b3,
                      ROM2_b4,  ROM2_b5,  ROM2_b6,  ROM2_b7,
                      ROM2_b8,  ROM2_b9,  ROM2_b10, ROM2_b11,
                      ROM2_b12, ROM2_b13, ROM2_b14, ROM2_b15};

    // Split the packed index into its three digits, d0 in the low bits.
    for (genvar k = 0; k < 3; k++) begin : g_digit
        assign w_digit[k] = req_idx[(k+1)*DIG_W-1 -: DIG_W];
    end

    assign req_ready = (r_state == ST_IDLE);
    assign w_accept  = req_valid && (r_state == ST_IDLE);
    assign ROM_CEN   = r_romCen;
    assign out_valid = r_outValid;
    assign MA0       = r_ma[0];
    assign MA1       = r_ma[1];
    assign MA2       = r_ma[2];
    assign TF0       = r_tf[0];
    assign TF1       = r_tf[1];
    assign TF2       = r_tf[2];

    // One selector per ROM, driven by the bank select captured at accept.
    bank_sel16 #(.D_W(D_W)) u_sel0 (.i_data(w_rom0), .i_sel(r_bs[0]), .o_data(w_sel[0]));
    bank_sel16 #(.D_W(D_W)) u_sel1 (.i_data(w_rom1), .i_sel(r_bs[1]), .o_data(w_sel[1]));
    bank_sel16 #(.D_W(D_W)) u_sel2 (.i_data(w_rom2), .i_sel(r_bs[2]), .o_data(w_sel[2]));

    // Next-state decode. Each request walks the four states in a fixed order;
    // only IDLE looks at req_valid and only OUT looks at out_ready.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (req_valid) w_nextState = ST_ISSUE;
            ST_ISSUE: w_nextState = ST_CAPT;
            ST_CAPT:  w_nextState = ST_OUT;
            ST_OUT:   if (out_ready) w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // State register plus the chip enable. ROM_CEN is registered from the
    // next state so it is low exactly for the single ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_romCen <= 1'b1;
        end else begin
            r_state  <= w_nextState;
            r_romCen <= (w_nextState != ST_ISSUE);
        end
    end

    // Address and bank-select capture at accept. Addresses are deliberately
    // left holding their last value between requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                r_ma[k] <= '0;
                r_bs[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = 0; k < 3; k++) begin
                r_ma[k] <= w_digit[k][DIG_W-1:4];
                r_bs[k] <= w_digit[k][3:0];
            end
        end
    end

    // Result capture. The ROM data is valid during CAPT, so the selected
    // words and out_valid load together at the end of that cycle and then
    // hold until the consumer takes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                r_tf[k] <= '0;
            end
        end else if (r_state == ST_CAPT) begin
            r_outValid <= 1'b1;
            for (int k = 0; k < 3; k++) begin
                r_tf[k] <= w_sel[k];
            end
        end else if ((r_state == ST_OUT) && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tw_rom_reader.sv
// ---------------------------------------------------------------------------
// tb_tw_rom_reader
// Directed bench for tw_rom_reader. A behavioural ROM latches each address
// on a ROM_CEN-low edge and returns word {k, bank, addr} on every bank.
// ---------------------------------------------------------------------------
module tb_tw_rom_reader;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int IW = 3 * (AW + 4);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [IW-1:0] req_idx = '0;
    logic          ROM_CEN;
    logic [AW-1:0] MA0, MA1, MA2;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] TF0, TF1, TF2;
    logic [DW-1:0] rom0 [16];
    logic [DW-1:0] rom1 [16];
    logic [DW-1:0] rom2 [16];
    logic [AW-1:0] romAddr0 = '0;
    logic [AW-1:0] romAddr1 = '0;
    logic [AW-1:0] romAddr2 = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acceptCyc [4];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] mkWord(input int k, input int j, input int a);
        logic [1:0] kk;
        logic [3:0] jj;
        logic [5:0] aa;
        kk = k[1:0];
        jj = j[3:0];
        aa = a[5:0];
        return {4'b0, kk, jj, aa};
    endfunction

    // Synchronous ROM model: address registered on a chip-enabled edge.
    always @(posedge clk) begin
        if (!ROM_CEN) begin
            romAddr0 <= MA0;
            romAddr1 <= MA1;
            romAddr2 <= MA2;
        end
    end

    always_comb begin
        for (int j = 0; j < 16; j++) begin
            rom0[j] = mkWord(0, j, int'(romAddr0));
            rom1[j] = mkWord(1, j, int'(romAddr1));
            rom2[j] = mkWord(2, j, int'(romAddr2));
        end
    end

    tw_rom_reader #(.D_W(DW), .A_W(AW), .NBANK(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
        .ROM_CEN(ROM_CEN), .MA0(MA0), .MA1(MA1), .MA2(MA2),
        .ROM0_b0(rom0[0]),   .ROM0_b1(rom0[1]),   .ROM0_b2(rom0[2]),   .ROM0_b3(rom0[3]),
        .ROM0_b4(rom0[4]),   .ROM0_b5(rom0[5]),   .ROM0_b6(rom0[6]),   .ROM0_b7(rom0[7]),
        .ROM0_b8(rom0[8]),   .ROM0_b9(rom0[9]),   .ROM0_b10(rom0[10]), .ROM0_b11(rom0[11]),
        .ROM0_b12(rom0[12]), .ROM0_b13(rom0[13]), .ROM0_b14(rom0[14]), .ROM0_b15(rom0[15]),
        .ROM1_b0(rom1[0]),   .ROM1_b1(rom1[1]),   .ROM1_b2(rom1[2]),   .ROM1_b3(rom1[3]),
        .ROM1_b4(rom1[4]),   .ROM1_b5(rom1[5]),   .ROM1_b6(rom1[6]),   .ROM1_b7(rom1[7]),
        .ROM1_b8(rom1[8]),   .ROM1_b9(rom1[9]),   .ROM1_b10(rom1[10]), .ROM1_b11(rom1[11]),
        .ROM1_b12(rom1[12]), .ROM1_b13(rom1[13]), .ROM1_b14(rom1[14]), .ROM1_b15(rom1[15]),
        .ROM2_b0(rom2[0]),   .ROM2_b1(rom2[1]),   .ROM2_b2(rom2[2]),   .ROM2_b3(rom2[3]),
        .ROM2_b4(rom2[4]),   .ROM2_b5(rom2[5]),   .ROM2_b6(rom2[6]),   .ROM2_b7(rom2[7]),
        .ROM2_b8(rom2[8]),   .ROM2_b9(rom2[9]),   .ROM2_b10(rom2[10]), .ROM2_b11(rom2[11]),
        .ROM2_b12(rom2[12]), .ROM2_b13(rom2[13]), .ROM2_b14(rom2[14]), .ROM2_b15(rom2[15]),
        .out_valid(out_valid), .out_ready(out_ready),
        .TF0(TF0), .TF1(TF1), .TF2(TF2)
    );

    // Advance one clock and return to the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request: digit k = {addr ak, bank bk}.
    task automatic applyStimulus(input int a0, input int b0, input int a1, input int b1,
                                 input int a2, input int b2);
        logic [AW+3:0] d0, d1, d2;
        d0 = {a0[AW-1:0], b0[3:0]};
        d1 = {a1[AW-1:0], b1[3:0]};
        d2 = {a2[AW-1:0], b2[3:0]};
        req_idx   = {d2, d1, d0};
        req_valid = 1'b1;
    endtask

    task automatic waitOutValid(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_outValidTimeout"}, {31'b0, out_valid}, 32'd1);
    endtask

    task automatic waitReady(input string tag);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_readyTimeout"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        // Reset held for three cycles
        @(negedge clk);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checkOutput("rst_cen",      {31'b0, ROM_CEN},   32'd1);
        checkOutput("rst_ma0",      {26'b0, MA0},       32'd0);
        checkOutput("rst_ma1",      {26'b0, MA1},       32'd0);
        checkOutput("rst_ma2",      {26'b0, MA2},       32'd0);
        checkOutput("rst_tf0",      {16'b0, TF0},       32'd0);
        checkOutput("rst_tf1",      {16'b0, TF1},       32'd0);
        checkOutput("rst_tf2",      {16'b0, TF2},       32'd0);
        checkOutput("rst_outValid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_reqReady", {31'b0, req_ready}, 32'd1);

        // Single request with hand-computed words
        out_ready = 1'b1;
        applyStimulus(5, 3, 9, 15, 0, 0);
        checkOutput("single_readyBeforeAccept", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        checkOutput("single_issueCen",   {31'b0, ROM_CEN},   32'd0);
        checkOutput("single_issueMa0",   {26'b0, MA0},       32'd5);
        checkOutput("single_issueMa1",   {26'b0, MA1},       32'd9);
        checkOutput("single_issueMa2",   {26'b0, MA2},       32'd0);
        checkOutput("single_issueReady", {31'b0, req_ready}, 32'd0);
        checkOutput("single_issueValid", {31'b0, out_valid}, 32'd0);
        tick();
        checkOutput("single_captCen",    {31'b0, ROM_CEN},   32'd1);
        checkOutput("single_captValid",  {31'b0, out_valid}, 32'd0);
        tick();
        checkOutput("single_outValid",   {31'b0, out_valid}, 32'd1);
        checkOutput("single_tf0",        {16'b0, TF0},       32'h00C5);
        checkOutput("single_tf1",        {16'b0, TF1},       32'h07C9);
        checkOutput("single_tf2",        {16'b0, TF2},       32'h0800);
        checkOutput("single_outCen",     {31'b0, ROM_CEN},   32'd1);
        tick();
        checkOutput("single_afterHsValid", {31'b0, out_valid}, 32'd0);
        checkOutput("single_afterHsReady", {31'b0, req_ready}, 32'd1);
        checkOutput("single_afterHsMa0",   {26'b0, MA0},       32'd5);

        // Backpressure: output held for ten cycles, a competing request ignored
        out_ready = 1'b0;
        applyStimulus(1, 2, 2, 4, 3, 6);
        tick();
        applyStimulus(7, 7, 7, 7, 7, 7);
        waitOutValid("bp");
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("bp_tf0_%0d", i),   {16'b0, TF0},       32'h0081);
            checkOutput($sformatf("bp_tf1_%0d", i),   {16'b0, TF1},       32'h0502);
            checkOutput($sformatf("bp_tf2_%0d", i),   {16'b0, TF2},       32'h0983);
            checkOutput($sformatf("bp_ready_%0d", i), {31'b0, req_ready}, 32'd0);
            checkOutput($sformatf("bp_cen_%0d", i),   {31'b0, ROM_CEN},   32'd1);
            checkOutput($sformatf("bp_valid_%0d", i), {31'b0, out_valid}, 32'd1);
            tick();
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("bp_releaseValid", {31'b0, out_valid}, 32'd0);
        checkOutput("bp_releaseReady", {31'b0, req_ready}, 32'd1);
        tick();
        checkOutput("bp_noLateAcceptCen", {31'b0, ROM_CEN},   32'd1);
        checkOutput("bp_noLateAcceptMa0", {26'b0, MA0},       32'd1);

        // Back-to-back requests with req_valid held high
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(10 + i, i, 20 + i, 4 + i, 30 + i, 8 + i);
            waitReady($sformatf("b2b_%0d", i));
            acceptCyc[i] = cyc;
            tick();
            waitOutValid($sformatf("b2b_%0d", i));
            checkOutput($sformatf("b2b_tf0_%0d", i), {16'b0, TF0}, {16'b0, mkWord(0, i,     10 + i)});
            checkOutput($sformatf("b2b_tf1_%0d", i), {16'b0, TF1}, {16'b0, mkWord(1, 4 + i, 20 + i)});
            checkOutput($sformatf("b2b_tf2_%0d", i), {16'b0, TF2}, {16'b0, mkWord(2, 8 + i, 30 + i)});
            if (i > 0) begin
                checkOutput($sformatf("b2b_spacing_%0d", i), acceptCyc[i] - acceptCyc[i-1], 32'd4);
            end
            tick();
        end
        req_valid = 1'b0;
        waitReady("b2b_end");

        // Reset asserted during the ISSUE cycle
        applyStimulus(33, 5, 34, 6, 35, 7);
        tick();
        req_valid = 1'b0;
        checkOutput("mid_issueCen", {31'b0, ROM_CEN}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_asyncCen",   {31'b0, ROM_CEN},   32'd1);
        checkOutput("mid_asyncReady", {31'b0, req_ready}, 32'd1);
        checkOutput("mid_asyncMa0",   {26'b0, MA0},       32'd0);
        checkOutput("mid_asyncTf0",   {16'b0, TF0},       32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("mid_noValid_%0d", i), {31'b0, out_valid}, 32'd0);
        end
        checkOutput("mid_readyAfter", {31'b0, req_ready}, 32'd1);

        // Bank sweep across all sixteen selects
        for (int b = 0; b < 16; b++) begin
            applyStimulus(b, b, 63 - b, 15 - b, (b * 3) % 64, b ^ 5);
            waitReady($sformatf("sweep_%0d", b));
            tick();
            req_valid = 1'b0;
            waitOutValid($sformatf("sweep_%0d", b));
            checkOutput($sformatf("sweep_tf0_%0d", b), {16'b0, TF0}, {16'b0, mkWord(0, b,      b)});
            checkOutput($sformatf("sweep_tf1_%0d", b), {16'b0, TF1}, {16'b0, mkWord(1, 15 - b, 63 - b)});
            checkOutput($sformatf("sweep_tf2_%0d", b), {16'b0, TF2}, {16'b0, mkWord(2, b ^ 5,  (b * 3) % 64)});
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
